// File: rtl/gl_tri_dispatch.sv
// gl_tri_dispatch
//
// Collects three vertices from one of two requesters and hands them to a
// rasterizer as a single triangle. A requester is granted in IDLE, keeps
// the grant for exactly three accepted vertices, then the block issues a
// one-cycle start pulse and waits for the rasterizer's completion edge
// (or a watchdog expiry) before returning to IDLE. When both requesters
// are valid in IDLE, the one that did not win last time is granted.
//
// Vertex word layout: x in [95:64], y in [63:32] (default width).
//
// Parameters
//   VERTEX_TYPE_SIZE  vertex word width
//   TIMEOUT           WAIT watchdog limit in cycles, 0 disables it
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   s0_valid     requester 0 presents a vertex
//   s0_vertex    requester 0 vertex data
//   s0_ready     requester 0 vertex accepted when s0_valid is high
//   s1_valid     requester 1 presents a vertex
//   s1_vertex    requester 1 vertex data
//   s1_ready     requester 1 vertex accepted when s1_valid is high
//   rast_start   one-cycle start pulse to the rasterizer
//   rast_v1..3   triangle vertices in acceptance order
//   rast_done    rasterizer ready (may stay high; rising edge used)
//   busy         high whenever not in IDLE
//   grant_id     requester currently or most recently granted
//   tri_count    number of completed triangles (wraps)
//   timeout_err  sticky watchdog flag, cleared only by reset
module gl_tri_dispatch #(
  parameter int VERTEX_TYPE_SIZE = 96,
  parameter int TIMEOUT          = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s0_valid,
  input  logic [VERTEX_TYPE_SIZE-1:0] s0_vertex,
  output logic                        s0_ready,
  input  logic                        s1_valid,
  input  logic [VERTEX_TYPE_SIZE-1:0] s1_vertex,
  output logic                        s1_ready,
  output logic                        rast_start,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v1,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v2,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v3,
  input  logic                        rast_done,
  output logic                        busy,
  output logic                        grant_id,
  output logic [15:0]                 tri_count,
  output logic                        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic                        grant_q, grant_d;
  logic                        last_grant_q, last_grant_d;
  logic [1:0]                  vcnt_q, vcnt_d;
  logic [15:0]                 wd_q, wd_d;
  logic                        rast_done_q;
  logic [VERTEX_TYPE_SIZE-1:0] v1_q, v1_d;
  logic [VERTEX_TYPE_SIZE-1:0] v2_q, v2_d;
  logic [VERTEX_TYPE_SIZE-1:0] v3_q, v3_d;
  logic [15:0]                 tri_count_q, tri_count_d;
  logic                        timeout_q, timeout_d;
  logic                        s0_ready_q, s1_ready_q;
  logic                        rast_start_q, busy_q;

  logic                        done_edge;
  logic                        accept;
  logic [VERTEX_TYPE_SIZE-1:0] acc_vertex;
  logic                        wd_limit;

  // Rasterizer ready may be held high; only a fresh rising edge completes.
  assign done_edge  = rast_done && !rast_done_q;

  // Ready flops mirror (state==LOAD && grant==N), so a handshake on the
  // granted port is the acceptance condition.
  assign accept     = grant_q ? (s1_valid && s1_ready_q) : (s0_valid && s0_ready_q);
  assign acc_vertex = grant_q ? s1_vertex : s0_vertex;

  // Counter reaches the limit on the edge where it would step to TIMEOUT,
  // giving exactly TIMEOUT cycles in WAIT.
  assign wd_limit   = (TIMEOUT != 0) && (({1'b0, wd_q} + 17'd1) == 17'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    vcnt_d       = vcnt_q;
    wd_d         = '0;
    v1_d         = v1_q;
    v2_d         = v2_q;
    v3_d         = v3_q;
    tri_count_d  = tri_count_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (s0_valid || s1_valid) begin
          // Tie goes to the requester that did not win last time.
          grant_d = (s0_valid && s1_valid) ? !last_grant_q : s1_valid;
          vcnt_d  = 2'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          case (vcnt_q)
            2'd0:    v1_d = acc_vertex;
            2'd1:    v2_d = acc_vertex;
            default: v3_d = acc_vertex;
          endcase
          if (vcnt_q == 2'd2) begin
            vcnt_d       = 2'd0;
            last_grant_d = grant_q;
            state_d      = S_START;
          end else begin
            vcnt_d = vcnt_q + 2'd1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      default: begin
        // Completion wins over a simultaneous watchdog expiry.
        if (done_edge) begin
          tri_count_d = tri_count_q + 16'd1;
          state_d     = S_IDLE;
        end else if (wd_limit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      vcnt_q       <= 2'd0;
      wd_q         <= 16'd0;
      rast_done_q  <= 1'b0;
      v1_q         <= '0;
      v2_q         <= '0;
      v3_q         <= '0;
      tri_count_q  <= 16'd0;
      timeout_q    <= 1'b0;
      s0_ready_q   <= 1'b0;
      s1_ready_q   <= 1'b0;
      rast_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      vcnt_q       <= vcnt_d;
      wd_q         <= wd_d;
      rast_done_q  <= rast_done;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      tri_count_q  <= tri_count_d;
      timeout_q    <= timeout_d;
      // Outputs decoded from next state so they are flop outputs.
      s0_ready_q   <= (state_d == S_LOAD) && !grant_d;
      s1_ready_q   <= (state_d == S_LOAD) && grant_d;
      rast_start_q <= (state_d == S_START);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign s0_ready    = s0_ready_q;
  assign s1_ready    = s1_ready_q;
  assign rast_start  = rast_start_q;
  assign rast_v1     = v1_q;
  assign rast_v2     = v2_q;
  assign rast_v3     = v3_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign tri_count   = tri_count_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/gl_tri_dispatch.md
GL_TRI_DISPATCH -- requirements
Module: gl_tri_dispatch

Interface
REQ-001 SHALL have parameter VERTEX_TYPE_SIZE, default 96, giving the vertex word width; x in [95:64], y in [63:32].
REQ-002 SHALL have parameter TIMEOUT, default 65535, giving the WAIT watchdog limit in cycles; value 0 disables the watchdog.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port s0_valid  input  1  requester 0 presents a vertex.
REQ-006 SHALL have port s0_vertex  input  VERTEX_TYPE_SIZE  requester 0 vertex data.
REQ-007 SHALL have port s0_ready  output  1  requester 0 vertex accepted this cycle when s0_valid is also high.
REQ-008 SHALL have ports s1_valid, s1_vertex and s1_ready, with the same directions, widths and meanings as the s0 ports, for requester 1.
REQ-009 SHALL have port rast_start  output  1  one-cycle start pulse to the rasterizer's fifo_ready.
REQ-010 SHALL have ports rast_v1, rast_v2 and rast_v3  output  VERTEX_TYPE_SIZE each  triangle vertices in acceptance order, driving fifo_in1/2/3.
REQ-011 SHALL have port rast_done  input  1  rasterizer raster_ready; may be sticky-high; only its rising edge is used.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port grant_id  output  1  requester currently or most recently granted.
REQ-014 SHALL have port tri_count  output  16  triangles completed.
REQ-015 SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-016 SHALL implement the states IDLE, LOAD, START and WAIT, with all outputs registered.
REQ-017 In IDLE, if any sN_valid is high, the block SHALL latch a grant and go to LOAD next cycle.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester not equal to last_grant is granted (round-robin).
REQ-018 A grant SHALL be locked for exactly 3 vertex acceptances; the other requester's ready stays low throughout.
REQ-019 sN_ready SHALL be high only when state==LOAD and grant_id==N.
- A vertex is accepted on a clock edge where valid&&ready.
- The 1st, 2nd and 3rd accepted vertices are stored into rast_v1, rast_v2 and rast_v3 respectively.
- Idle cycles (valid low) inside LOAD are allowed and SHALL NOT advance the 2-bit vertex counter.
REQ-020 On the edge accepting the 3rd vertex, the block SHALL go to START and last_grant SHALL be set to grant_id.
- rast_start is high for exactly the one cycle spent in START.
- The next state is WAIT.
REQ-021 rast_v1..3 SHALL remain stable from START until the block leaves WAIT.
REQ-022 rast_done SHALL be sampled into a delay register every cycle; done_edge = rast_done && !rast_done_q.
REQ-023 In WAIT, on done_edge the block SHALL increment tri_count (wrapping 0xFFFF->0x0000) and go to IDLE.
REQ-024 A done_edge occurring outside WAIT SHALL be ignored.
REQ-025 In WAIT, a 16-bit watchdog counter SHALL count from 0 each cycle.
- The watchdog counter clears on entry to WAIT.
- When it reaches TIMEOUT (nonzero), timeout_err is set, the block goes to IDLE, and tri_count is not incremented.
REQ-026 If done_edge and the watchdog limit occur in the same cycle, done SHALL take priority: count++, no error.
REQ-027 Minimum throughput SHALL be 1 (IDLE) + 3 (LOAD) + 1 (START) + 1 (WAIT minimum) = 6 cycles per triangle.
REQ-028 timeout_err SHALL clear only on reset.

Reset
REQ-029 While rst_n is low, state SHALL be IDLE and the outputs SHALL be:
- s0_ready, s1_ready, rast_start, busy, timeout_err = 0.
- tri_count = 0.
- grant_id = 0; last_grant = 1, so requester 0 wins the first tie.
- rast_v1..3 = 0; vertex counter, watchdog counter and rast_done_q = 0.
REQ-030 Reset asserted mid-LOAD or mid-WAIT SHALL discard any partially assembled triangle; no rast_start is produced afterward for it.

Verification
REQ-031 Single requester: s0 supplies A, B, C back-to-back; rast_done rises 4 cycles after rast_start.
- Required: rast_v1/2/3 = A/B/C, one rast_start pulse, tri_count=1, s1_ready never high.
REQ-032 Contention: s0_valid and s1_valid held high for 4 triangles.
- Required: grants 0, 1, 0, 1.
- Required: each requester sees exactly 3 ready cycles per triangle, with no interleaving.
REQ-033 Sticky done: rast_done held high permanently after the first triangle.
- Required: the second triangle waits in WAIT until rast_done drops low and rises again; tri_count increments only once per rising edge.
REQ-034 Watchdog: TIMEOUT=10 and rast_done held low.
- Required: busy drops 10 cycles after WAIT entry, timeout_err=1, tri_count unchanged.
- Required: the next triangle is still processed normally.
REQ-035 Reset mid-operation: rst_n pulsed low after 2 vertices accepted.
- Required: all outputs return to their reset values asynchronously.
- Required: the next 3 vertices form a fresh triangle starting at rast_v1.
REQ-036 Wrap: tri_count preloaded to 0xFFFF via 65535 completions (or by force).
- Required: the next completion gives tri_count=0x0000.
